// File: rtl/fibonacci_checker_if.sv
// Beat-level stream bus between a Fibonacci generator and the checker.
// A beat carries one or two consecutive terms, qualified by a valid/ready handshake.
interface fibonacci_checker_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic             in_two;
   logic [WIDTH-1:0] in_num0;
   logic [WIDTH-1:0] in_num1;

   modport master (
      output in_valid,
      output in_two,
      output in_num0,
      output in_num1,
      input  in_ready
   );

   modport slave (
      input  in_valid,
      input  in_two,
      input  in_num0,
      input  in_num1,
      output in_ready
   );
endinterface

// File: rtl/fibonacci_checker.sv
// Checks a one-or-two-terms-per-beat stream against 1, 1, 2, 3, 5, ... mod 2^WIDTH,
// counts matched terms up to N and latches diagnostics on the first mismatch.
module fibonacci_checker #(
   parameter int WIDTH = 16,
   parameter int N     = 10,
   parameter int CW    = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   fibonacci_checker_if.slave bus,
   output logic [CW-1:0]    count,
   output logic             done,
   output logic             error,
   output logic [CW-1:0]    err_index,
   output logic [WIDTH-1:0] err_expected,
   output logic [WIDTH-1:0] err_got
);

   typedef enum logic [1:0] {
      IDLE,
      CHECK,
      DONE,
      ERROR
   } state_t;

   localparam logic [CW-1:0] TERMS = CW'(N);
   localparam logic [CW-1:0] ONE   = CW'(1);
   localparam logic [CW-1:0] TWO   = CW'(2);

   state_t           state;
   state_t           next_state;

   logic [WIDTH-1:0] exp_a;
   logic [WIDTH-1:0] exp_b;
   logic [WIDTH-1:0] sum_ab;
   logic [WIDTH-1:0] sum_abb;

   logic [CW-1:0]    remaining;
   logic [CW-1:0]    step;
   logic [CW-1:0]    count_pass;
   logic [CW-1:0]    count_plus1;

   logic             two_lane;
   logic             lane0_ok;
   logic             lane1_ok;
   logic             accept;
   logic             pass;
   logic             fail0;
   logic             fail1;
   logic             finish;

   // With exactly one term left, a double beat collapses to a single one and lane1 is ignored.
   always_comb begin
      remaining   = TERMS - count;
      two_lane    = bus.in_two && (remaining >= TWO);
      step        = two_lane ? TWO : ONE;
      count_pass  = count + step;
      count_plus1 = count + ONE;
      sum_ab      = exp_a + exp_b;
      sum_abb     = sum_ab + exp_b;
      lane0_ok    = (bus.in_num0 == exp_a);
      lane1_ok    = (bus.in_num1 == exp_b);
      accept      = (state == CHECK) && bus.in_valid && !start;
      pass        = accept && lane0_ok && (!two_lane || lane1_ok);
      fail0       = accept && !lane0_ok;
      fail1       = accept && lane0_ok && two_lane && !lane1_ok;
      finish      = pass && (count_pass == TERMS);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      if (start) begin
         next_state = CHECK;
      end else begin
         case (state)
            CHECK: begin
               if (fail0 || fail1) begin
                  next_state = ERROR;
               end else if (finish) begin
                  next_state = DONE;
               end
            end
            default: next_state = state;
         endcase
      end
   end

   // Status flags decode the registered state only, so in_ready never depends on in_valid.
   always_comb begin
      bus.in_ready = (state == CHECK);
      done         = (state == DONE);
      error        = (state == ERROR);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         exp_a        <= WIDTH'(1);
         exp_b        <= WIDTH'(1);
         count        <= '0;
         err_index    <= '0;
         err_expected <= '0;
         err_got      <= '0;
      end else if (start) begin
         exp_a        <= WIDTH'(1);
         exp_b        <= WIDTH'(1);
         count        <= '0;
         err_index    <= '0;
         err_expected <= '0;
         err_got      <= '0;
      end else if (pass) begin
         count <= count_pass;
         if (two_lane) begin
            exp_a <= sum_ab;
            exp_b <= sum_abb;
         end else begin
            exp_a <= exp_b;
            exp_b <= sum_ab;
         end
      end else if (fail0) begin
         err_index    <= count;
         err_expected <= exp_a;
         err_got      <= bus.in_num0;
      end else if (fail1) begin
         count        <= count_plus1;
         err_index    <= count_plus1;
         err_expected <= exp_b;
         err_got      <= bus.in_num1;
      end
   end

endmodule

// File: tb/tb_fibonacci_checker.sv
// Drives three checkers (N = 10, 30, 3) from one stream and compares every output each cycle
// against a term-list reference model of the Fibonacci checking rules.
module tb_fibonacci_checker;

   localparam int W = 16;

   logic          clk;
   logic          rst;
   logic          start;
   logic          valid;
   logic          two;
   logic [W-1:0]  num0;
   logic [W-1:0]  num1;

   logic [15:0]   count_o    [3];
   logic          done_o     [3];
   logic          error_o    [3];
   logic [15:0]   eidx_o     [3];
   logic [W-1:0]  eexp_o     [3];
   logic [W-1:0]  egot_o     [3];
   logic          ready_o    [3];

   int            n_checks;
   int            n_fail;

   logic [W-1:0]  fib        [64];
   int            m_st       [3];
   int            m_cnt      [3];
   int            m_eidx     [3];
   logic [W-1:0]  m_eexp     [3];
   logic [W-1:0]  m_egot     [3];

   fibonacci_checker_if #(.WIDTH(W)) bus0 ();
   fibonacci_checker_if #(.WIDTH(W)) bus1 ();
   fibonacci_checker_if #(.WIDTH(W)) bus2 ();

   assign bus0.in_valid = valid;
   assign bus0.in_two   = two;
   assign bus0.in_num0  = num0;
   assign bus0.in_num1  = num1;
   assign bus1.in_valid = valid;
   assign bus1.in_two   = two;
   assign bus1.in_num0  = num0;
   assign bus1.in_num1  = num1;
   assign bus2.in_valid = valid;
   assign bus2.in_two   = two;
   assign bus2.in_num0  = num0;
   assign bus2.in_num1  = num1;
   assign ready_o[0]    = bus0.in_ready;
   assign ready_o[1]    = bus1.in_ready;
   assign ready_o[2]    = bus2.in_ready;

   fibonacci_checker #(.WIDTH(W), .N(10), .CW(16)) dut0 (
      .clk(clk), .rst(rst), .start(start), .bus(bus0),
      .count(count_o[0]), .done(done_o[0]), .error(error_o[0]),
      .err_index(eidx_o[0]), .err_expected(eexp_o[0]), .err_got(egot_o[0])
   );

   fibonacci_checker #(.WIDTH(W), .N(30), .CW(16)) dut1 (
      .clk(clk), .rst(rst), .start(start), .bus(bus1),
      .count(count_o[1]), .done(done_o[1]), .error(error_o[1]),
      .err_index(eidx_o[1]), .err_expected(eexp_o[1]), .err_got(egot_o[1])
   );

   fibonacci_checker #(.WIDTH(W), .N(3), .CW(16)) dut2 (
      .clk(clk), .rst(rst), .start(start), .bus(bus2),
      .count(count_o[2]), .done(done_o[2]), .error(error_o[2]),
      .err_index(eidx_o[2]), .err_expected(eexp_o[2]), .err_got(egot_o[2])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int n_of(input int k);
      case (k)
         0:       return 10;
         1:       return 30;
         default: return 3;
      endcase
   endfunction

   task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // Model states: 0 idle, 1 checking, 2 done, 3 error.
   task automatic model_reset();
      for (int k = 0; k < 3; k++) begin
         m_st[k]   = 0;
         m_cnt[k]  = 0;
         m_eidx[k] = 0;
         m_eexp[k] = '0;
         m_egot[k] = '0;
      end
   endtask

   task automatic model_update();
      logic [W-1:0] got [2];
      int           terms;
      got[0] = num0;
      got[1] = num1;
      for (int k = 0; k < 3; k++) begin
         if (start) begin
            m_st[k]   = 1;
            m_cnt[k]  = 0;
            m_eidx[k] = 0;
            m_eexp[k] = '0;
            m_egot[k] = '0;
         end else if (m_st[k] == 1 && valid) begin
            terms = (two && (n_of(k) - m_cnt[k] >= 2)) ? 2 : 1;
            for (int j = 0; j < terms; j++) begin
               if (m_st[k] == 1) begin
                  if (got[j] != fib[m_cnt[k]]) begin
                     m_st[k]   = 3;
                     m_eidx[k] = m_cnt[k];
                     m_eexp[k] = fib[m_cnt[k]];
                     m_egot[k] = got[j];
                  end else begin
                     m_cnt[k]++;
                  end
               end
            end
            if (m_st[k] == 1 && m_cnt[k] == n_of(k)) m_st[k] = 2;
         end
      end
   endtask

   task automatic compare_all();
      for (int k = 0; k < 3; k++) begin
         check_output($sformatf("dut%0d count", k),        32'(count_o[k]), 32'(m_cnt[k]));
         check_output($sformatf("dut%0d done", k),         32'(done_o[k]),  32'(m_st[k] == 2));
         check_output($sformatf("dut%0d error", k),        32'(error_o[k]), 32'(m_st[k] == 3));
         check_output($sformatf("dut%0d in_ready", k),     32'(ready_o[k]), 32'(m_st[k] == 1));
         check_output($sformatf("dut%0d err_index", k),    32'(eidx_o[k]),  32'(m_eidx[k]));
         check_output($sformatf("dut%0d err_expected", k), 32'(eexp_o[k]),  32'(m_eexp[k]));
         check_output($sformatf("dut%0d err_got", k),      32'(egot_o[k]),  32'(m_egot[k]));
      end
   endtask

   // Inputs change 1 time unit after a rising edge and are held through the next one.
   task automatic apply_stimulus(input logic s, input logic v, input logic t,
                                 input logic [W-1:0] a, input logic [W-1:0] b);
      start = s;
      valid = v;
      two   = t;
      num0  = a;
      num1  = b;
      @(posedge clk);
      model_update();
      #1;
      compare_all();
   endtask

   task automatic pulse_reset();
      #3 rst = 1'b0;
      #1;
      model_reset();
      compare_all();
      #2 rst = 1'b1;
   endtask

   function automatic int live_count();
      for (int k = 0; k < 3; k++) begin
         if (m_st[k] == 1) return m_cnt[k];
      end
      return 0;
   endfunction

   function automatic logic any_live();
      return (m_st[0] == 1) || (m_st[1] == 1) || (m_st[2] == 1);
   endfunction

   initial begin
      int           c;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         s;

      n_checks = 0;
      n_fail   = 0;
      fib[0]   = 16'd1;
      fib[1]   = 16'd1;
      for (int i = 2; i < 64; i++) fib[i] = fib[i-1] + fib[i-2];

      rst   = 1'b1;
      start = 1'b0;
      valid = 1'b0;
      two   = 1'b0;
      num0  = '0;
      num1  = '0;
      model_reset();
      #2 rst = 1'b0;
      #1 compare_all();
      @(negedge clk);
      rst = 1'b1;

      // Ten single beats to N=10.
      apply_stimulus(1, 0, 0, 0, 0);
      for (int i = 0; i < 10; i++) apply_stimulus(0, 1, 0, fib[i], 0);
      check_output("plan single done", 32'(done_o[0]), 32'd1);
      check_output("plan single ready", 32'(ready_o[0]), 32'd0);
      apply_stimulus(0, 0, 0, 0, 0);

      // Double beats through the 16-bit wrap for N=30; N=3 clips on its second beat.
      apply_stimulus(1, 0, 0, 0, 0);
      for (int i = 0; i < 15; i++) apply_stimulus(0, 1, 1, fib[2*i], fib[2*i+1]);
      check_output("plan wrap term24", 32'(fib[24]), 32'd9489);
      check_output("plan wrap count", 32'(count_o[1]), 32'd30);
      check_output("plan wrap done", 32'(done_o[1]), 32'd1);
      check_output("plan clip count", 32'(count_o[2]), 32'd3);

      // Lane0 mismatch at index 3, then recovery by start.
      apply_stimulus(1, 0, 0, 0, 0);
      apply_stimulus(0, 1, 0, 1, 0);
      apply_stimulus(0, 1, 0, 1, 0);
      apply_stimulus(0, 1, 0, 2, 0);
      apply_stimulus(0, 1, 0, 4, 0);
      check_output("plan err_index", 32'(eidx_o[0]), 32'd3);
      check_output("plan err_got", 32'(egot_o[0]), 32'd4);
      check_output("plan err_count", 32'(count_o[0]), 32'd3);
      apply_stimulus(1, 1, 0, 1, 0);
      apply_stimulus(0, 1, 0, 1, 0);
      check_output("plan restart count", 32'(count_o[0]), 32'd1);

      // Lane1 mismatch: ignored with one term left (N=3), reported otherwise (N=10).
      apply_stimulus(1, 0, 0, 0, 0);
      apply_stimulus(0, 1, 1, 1, 1);
      apply_stimulus(0, 1, 1, 2, 999);
      check_output("plan lane1 ignored", 32'(done_o[2]), 32'd1);
      apply_stimulus(1, 0, 0, 0, 0);
      apply_stimulus(0, 1, 1, 1, 1);
      apply_stimulus(0, 1, 1, 2, 7);
      check_output("plan lane1 err_got", 32'(egot_o[0]), 32'd7);
      check_output("plan lane1 count", 32'(count_o[0]), 32'd3);

      // Asynchronous reset mid-stream at count 4.
      apply_stimulus(1, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) apply_stimulus(0, 1, 0, fib[i], 0);
      pulse_reset();
      check_output("plan rst count", 32'(count_o[0]), 32'd0);
      apply_stimulus(0, 1, 0, 1, 0);
      apply_stimulus(1, 0, 0, 0, 0);
      apply_stimulus(0, 1, 0, 1, 0);
      apply_stimulus(0, 1, 0, 1, 0);
      check_output("plan post-rst count", 32'(count_o[0]), 32'd2);

      // Randomized stream: mostly correct terms, occasional corruption, starts and resets.
      for (int cyc = 0; cyc < 4000; cyc++) begin
         c = live_count();
         a = fib[c];
         b = fib[c+1];
         if ($urandom_range(0, 39) == 0) a = a ^ W'($urandom_range(1, 65535));
         if ($urandom_range(0, 39) == 0) b = b ^ W'($urandom_range(1, 65535));
         s = ($urandom_range(0, 99) < 2) || (!any_live() && $urandom_range(0, 5) == 0);
         apply_stimulus(s, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, a, b);
         if ($urandom_range(0, 299) == 0) pulse_reset();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fibonacci_checker.md
Name: fibonacci_checker

Overview:
Stream consumer that checks an incoming sequence of numbers against the Fibonacci sequence 1, 1, 2, 3, 5, … (mod 2^WIDTH). It accepts one or two numbers per cycle over a valid/ready handshake, which matches both single-rate and double-rate generators. It counts matched terms and reports completion after N terms. On the first mismatch it latches diagnostic data.

Parameters:
WIDTH, 16, data width; all arithmetic is modulo 2^WIDTH
N, 10, number of terms to check before reporting done (N >= 1)
CW, 16, width of count/index outputs (must hold N)

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-low
start  input  1  single-cycle pulse; (re)arms the checker from any state
in_valid  input  1  input beat valid
in_ready  output  1  checker accepts a beat this cycle
in_two  input  1  beat carries two terms (in_num0 first, then in_num1)
in_num0  input  WIDTH  first/only term of beat
in_num1  input  WIDTH  second term; ignored when in_two=0
count  output  CW  number of terms matched since last start
done  output  1  N terms matched, no error
error  output  1  sticky mismatch flag
err_index  output  CW  0-based sequence index of first mismatching term
err_expected  output  WIDTH  expected value at err_index
err_got  output  WIDTH  received value at err_index

Behaviour:
- Reset (rst=0, async): state IDLE. count, err_index, err_expected, err_got = 0. done, error, in_ready = 0. Expected pair {exp_a, exp_b} = {1, 1}.
- States: IDLE, CHECK, DONE, ERROR. in_ready = 1 only in CHECK (registered state decode, no combinational path from in_valid).
- start in any state: next state CHECK; {exp_a, exp_b} <= {1, 1}; count, err_* <= 0; done, error <= 0. If start and in_valid occur in the same cycle, start wins and the beat is not consumed (in_ready is low only in non-CHECK states; in CHECK with start, the beat is dropped and the sender must resend).
- Accept = CHECK && in_valid && !start. Latency is 1 cycle: outputs reflect the beat on the next clock edge.
- Single beat (in_two=0, or in_two=1 with exactly one term remaining):
  - compare in_num0 to exp_a.
  - On match: count += 1; {exp_a, exp_b} <= {exp_b, exp_a + exp_b}.
- Double beat (in_two=1, at least two terms remaining):
  - lane0 is compared to exp_a; lane1 is compared to exp_b.
  - Both match: count += 2; {exp_a, exp_b} <= {exp_a + exp_b, exp_a + 2*exp_b}.
- Remaining terms = N - count. In the one-remaining case, lane1 is ignored and not checked.
- Mismatch:
  - lane0 mismatch: nothing is counted, and lane1 is not checked.
  - lane0 match, lane1 mismatch: count += 1.
  - err_index = index of the failing term; err_expected and err_got are latched; error <= 1; next state ERROR.
- When count reaches N: done <= 1, next state DONE. In DONE and ERROR, in_ready = 0, and outputs hold until start or reset.
- Wrap-around: sums are truncated to WIDTH bits, with no saturation or overflow flag.
- Reset asserted mid-stream: immediate return to reset values; the sequence restarts only after reset deassertion followed by start.
- Beats with in_valid=0 change nothing.

Test Plan:
- Reset, start, then 10 single beats 1, 1, 2, 3, 5, 8, 13, 21, 34, 55 -> count steps 1..10, done=1 one cycle after last beat, in_ready=0 afterwards, error=0.
- Start, then 5 double beats (1,1)(2,3)(5,8)(13,21)(34,55) -> count 2, 4, 6, 8, 10, done=1.
- N=30, double beats of the true sequence through wrap -> index 24 expected 9489 (75025 mod 65536) is accepted, done=1 at count=30, no error.
- Start, single beats 1, 1, 2, 4 -> error=1, err_index=3, err_expected=3, err_got=4, count=3, state ERROR, in_ready=0. A subsequent start clears error and count and accepts 1 at index 0.
- N=3, double beats (1,1)(2,999) -> lane1 ignored, count=3, done=1, error=0. Double beat (1,1)(2,7) with N=10 -> error, err_index=3, err_expected=3, err_got=7, count=3.
- rst pulsed low mid-stream at count=4 -> all outputs 0 immediately (asynchronous reset). start then 1, 1 -> count=2, no error.
